// File: rtl/nexusv_pkg.sv
// Shared CLINT definitions: register offsets within the 64 KiB window,
// mtimecmp reset value and the bus slave state encoding.
package nexusv_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

    // All-ones keeps every timer interrupt quiet until software programs it.
    localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } clint_state_e;

endpackage

// File: rtl/nexusv_clint_timer.sv
// 64-bit mtime counter with a TICK_DIV prescaler. Bus writes to either half
// take priority over a coincident tick and leave the other half untouched.
module nexusv_clint_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [15:0] presc;
    logic [63:0] mtime;
    logic        tick;

    assign tick  = tick_en && (presc == 16'(TICK_DIV - 1));
    assign value = mtime;

    // Prescaler: free-running modulo TICK_DIV, unaffected by mtime writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (tick_en) begin
            presc <= tick ? '0 : presc + 16'd1;
        end
    end

    // mtime: write beats tick; wraps naturally at 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= '0;
        end else if (wr_lo) begin
            mtime[31:0] <= wdata;
        end else if (wr_hi) begin
            mtime[63:32] <= wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/nexusv_clint.sv
// Core-local interruptor: per-hart msip/mtimecmp registers, a shared mtime
// timer and a fixed two-cycle bus slave (request cycle, then ready cycle).
//
//   state   | meaning
//   IDLE    | waiting for bus_valid; request is decoded and committed on exit
//   RESP    | bus_ready high with registered read data; requests not accepted
module nexusv_clint import nexusv_pkg::*; #(
    parameter int          NUM_HARTS = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          bus_addr,
    input  logic [31:0]          bus_wdata,
    input  logic                 bus_write,
    input  logic                 bus_valid,
    output logic [31:0]          bus_rdata,
    output logic                 bus_ready,
    output logic [NUM_HARTS-1:0] mtip,
    output logic [NUM_HARTS-1:0] msip,
    output logic [63:0]          mtime_o
);

    clint_state_e                  state;
    logic                          ready_q;
    logic [31:0]                   rdata_q;
    logic [31:0]                   off;
    logic [15:0]                   off16;
    logic                          in_win;
    logic                          accept;
    logic                          wr_fire;
    logic                          mt_wr_lo;
    logic                          mt_wr_hi;
    logic [63:0]                   mtime;
    logic [31:0]                   rd_val;
    logic [NUM_HARTS-1:0][31:0]    hart_rd;

    assign off     = bus_addr - BASE_ADDR;
    assign in_win  = (off[31:16] == 16'h0000);
    assign off16   = off[15:0];
    assign accept  = (state == ST_IDLE) && bus_valid;
    assign wr_fire = accept && bus_write && in_win;

    assign mt_wr_lo = wr_fire && (off16 == CLINT_MTIME_OFF);
    assign mt_wr_hi = wr_fire && (off16 == CLINT_MTIME_OFF + 16'd4);

    nexusv_clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .tick_en (1'b1),
        .wr_lo   (mt_wr_lo),
        .wr_hi   (mt_wr_hi),
        .wdata   (bus_wdata),
        .value   (mtime)
    );

    assign mtime_o = mtime;

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        localparam logic [15:0] MSIP_A = CLINT_MSIP_OFF + 16'(4 * h);
        localparam logic [15:0] CMP_A  = CLINT_MTIMECMP_OFF + 16'(8 * h);

        logic        msip_r;
        logic [63:0] cmp_r;
        logic        mtip_r;

        // Software interrupt pending bit; only bit 0 of the write is kept.
        always_ff @(posedge clk) begin
            if (rst) begin
                msip_r <= 1'b0;
            end else if (wr_fire && (off16 == MSIP_A)) begin
                msip_r <= bus_wdata[0];
            end
        end

        // mtimecmp halves written independently.
        always_ff @(posedge clk) begin
            if (rst) begin
                cmp_r <= CLINT_MTIMECMP_RST;
            end else if (wr_fire && (off16 == CMP_A)) begin
                cmp_r[31:0] <= bus_wdata;
            end else if (wr_fire && (off16 == CMP_A + 16'd4)) begin
                cmp_r[63:32] <= bus_wdata;
            end
        end

        // Registered unsigned compare, one cycle behind mtime/mtimecmp.
        always_ff @(posedge clk) begin
            if (rst) begin
                mtip_r <= 1'b0;
            end else begin
                mtip_r <= (mtime >= cmp_r);
            end
        end

        assign hart_rd[h] = (off16 == MSIP_A)        ? {31'b0, msip_r} :
                            (off16 == CMP_A)         ? cmp_r[31:0]     :
                            (off16 == CMP_A + 16'd4) ? cmp_r[63:32]    : 32'h0;
        assign msip[h] = msip_r;
        assign mtip[h] = mtip_r;
    end

    // Read mux; register offsets are disjoint so per-hart terms can be OR-ed.
    always_comb begin
        rd_val = '0;
        if (in_win) begin
            if (off16 == CLINT_MTIME_OFF) begin
                rd_val = mtime[31:0];
            end else if (off16 == CLINT_MTIME_OFF + 16'd4) begin
                rd_val = mtime[63:32];
            end
            for (int h = 0; h < NUM_HARTS; h++) begin
                rd_val = rd_val | hart_rd[h];
            end
        end
    end

    // Bus slave FSM with registered ready and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus_valid) begin
                        state   <= ST_RESP;
                        ready_q <= 1'b1;
                        rdata_q <= bus_write ? 32'h0 : rd_val;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    // A reset arriving during the response cycle suppresses the completion.
    assign bus_ready = ready_q & ~rst;
    assign bus_rdata = bus_ready ? rdata_q : 32'h0;

endmodule

// File: tb/tb_nexusv_clint.sv
// Scoreboard bench for nexusv_clint: the driver queues the expected response
// of every access; a negedge monitor pops and checks it when bus_ready shows.
module tb_nexusv_clint;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_write, bus_valid, bus_ready;
    logic [1:0]  mtip, msip;
    logic [63:0] mtime_o;

    logic [31:0] p_addr = 32'h0, p_wdata = 32'h0, p_rdata;
    logic        p_write = 1'b0, p_valid = 1'b0, p_ready;
    logic [1:0]  p_mtip, p_msip;
    logic [63:0] p_mtime;

    always #5 clk = ~clk;

    nexusv_clint #(.NUM_HARTS(2), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_write(bus_write), .bus_valid(bus_valid), .bus_rdata(bus_rdata),
        .bus_ready(bus_ready), .mtip(mtip), .msip(msip), .mtime_o(mtime_o)
    );

    nexusv_clint #(.NUM_HARTS(2), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .bus_addr(p_addr), .bus_wdata(p_wdata),
        .bus_write(p_write), .bus_valid(p_valid), .bus_rdata(p_rdata),
        .bus_ready(p_ready), .mtip(p_mtip), .msip(p_msip), .mtime_o(p_mtime)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        chk_data;
        int          ready_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every ready must match a queued expectation; rdata idles at 0.
    always @(negedge clk) begin
        if (bus_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready: got ready=1 expected no access pending (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_ready_cycle"}, 64'(cyc), 64'(mon_e.ready_cyc));
                if (mon_e.chk_data)
                    check({mon_e.name, "_rdata"}, 64'(bus_rdata), 64'(mon_e.data));
            end
        end else begin
            check("rdata_zero_outside_resp", 64'(bus_rdata), 64'h0);
        end
    end

    // One access; rel >= 0 means the expected read value is mtime counted
    // from a reset release at cycle rel (TICK_DIV = 1).
    task automatic access(input string name, input logic [31:0] a, input logic wr,
                          input logic [31:0] d, input logic [31:0] exp_d,
                          input logic chk, input int rel);
        exp_t e;
        bit   got;
        @(negedge clk);
        bus_addr  = a;
        bus_wdata = d;
        bus_write = wr;
        bus_valid = 1'b1;
        e.name      = name;
        e.data      = (rel >= 0) ? 32'(cyc - rel) : exp_d;
        e.chk_data  = chk;
        e.ready_cyc = cyc + 1;
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_ready) begin
                got = 1'b1;
                break;
            end
        end
        bus_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ready expected ready within 4 cycles", name);
        end
    endtask

    initial begin
        int          r;
        logic [63:0] t0, m1;
        logic [31:0] v, mlo;
        int          ci, tv, tr;

        rst = 1'b1;
        bus_addr = '0; bus_wdata = '0; bus_write = 1'b0; bus_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_mtime", mtime_o, 64'h0);
        check("reset_msip", 64'(msip), 64'h0);
        check("reset_mtip", 64'(mtip), 64'h0);
        rst = 1'b0;
        r = cyc;
        check("mtime_zero_first_cycle", mtime_o, 64'h0);
        @(negedge clk);
        check("mtime_one_after_release", mtime_o, 64'h1);

        // Prescaler
        t0 = p_mtime;
        repeat (100) @(negedge clk);
        check("prescaler_25_in_100", p_mtime - t0, 64'd25);

        // Reset defaults through the bus
        access("rd_cmp0_lo", 32'h0200_4000, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b1, -1);
        access("rd_cmp1_hi", 32'h0200_400C, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b1, -1);
        access("rd_mtime_lo", 32'h0200_BFF8, 1'b0, 32'h0, 32'h0, 1'b1, r);
        access("rd_mtime_hi", 32'h0200_BFFC, 1'b0, 32'h0, 32'h0, 1'b1, -1);
        check("default_mtip", 64'(mtip), 64'h0);
        check("default_msip", 64'(msip), 64'h0);

        // Software interrupt
        access("wr_msip1", 32'h0200_0004, 1'b1, 32'h1, 32'h0, 1'b0, -1);
        check("msip_set_on_ready", 64'(msip), 64'h2);
        access("rd_msip1", 32'h0200_0004, 1'b0, 32'h0, 32'h1, 1'b1, -1);
        access("wr_msip2_absent", 32'h0200_0008, 1'b1, 32'h1, 32'h0, 1'b0, -1);
        access("rd_msip2_absent", 32'h0200_0008, 1'b0, 32'h0, 32'h0, 1'b1, -1);
        check("msip_after_absent_hart", 64'(msip), 64'h2);
        access("wr_msip1_clr", 32'h0200_0004, 1'b1, 32'hFFFF_FFFE, 32'h0, 1'b0, -1);
        check("msip_cleared", 64'(msip), 64'h0);

        // Unmapped and out-of-window
        access("rd_unmapped", 32'h0200_8000, 1'b0, 32'h0, 32'h0, 1'b1, -1);
        access("rd_out_of_window", 32'h0300_BFF8, 1'b0, 32'h0, 32'h0, 1'b1, -1);
        access("wr_out_of_window", 32'h0201_4000, 1'b1, 32'h0, 32'h0, 1'b0, -1);
        access("rd_cmp0_lo_intact", 32'h0200_4000, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b1, -1);

        // Timer compare
        access("wr_cmp0_hi", 32'h0200_4004, 1'b1, 32'h0, 32'h0, 1'b0, -1);
        check("mtip0_low_before_cmp", 64'(mtip[0]), 64'h0);
        m1 = mtime_o;
        v  = m1[31:0] + 32'd21;
        ci = cyc + 1;
        access("wr_cmp0_lo", 32'h0200_4000, 1'b1, v, 32'h0, 1'b0, -1);
        tv = -1;
        tr = -1;
        for (int i = 0; i < 60; i++) begin
            if (mtime_o[31:0] == v && tv < 0) tv = cyc;
            if (mtip[0]) begin
                tr = cyc;
                break;
            end
            @(negedge clk);
        end
        check("mtip0_rise_from_request", 64'(tr - ci), 64'd21);
        check("mtip0_rise_after_match", 64'(tr - tv), 64'd1);
        access("wr_cmp0_lo_max", 32'h0200_4000, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, -1);
        check("mtip0_held_on_ready", 64'(mtip[0]), 64'h1);
        @(negedge clk);
        check("mtip0_fall", 64'(mtip[0]), 64'h0);

        // Wrap and write priority
        @(negedge clk);
        mlo = mtime_o[31:0] + 32'd1;
        access("wr_mtime_hi", 32'h0200_BFFC, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, -1);
        check("mtime_hi_write_lo_holds", mtime_o, {32'hFFFF_FFFF, mlo});
        access("wr_mtime_lo", 32'h0200_BFF8, 1'b1, 32'hFFFF_FFFE, 32'h0, 1'b0, -1);
        check("mtime_write_beats_tick", mtime_o, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        check("mtime_max", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        check("mtime_wrap", mtime_o, 64'h0);

        // Reset during the response cycle
        access("wr_msip0", 32'h0200_0000, 1'b1, 32'h1, 32'h0, 1'b0, -1);
        check("msip0_set", 64'(msip), 64'h1);
        @(negedge clk);
        bus_addr = 32'h0200_0004; bus_wdata = 32'h1; bus_write = 1'b1; bus_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_msip", 64'(msip), 64'h0);
        check("abort_mtip", 64'(mtip), 64'h0);
        check("abort_mtime", mtime_o, 64'h0);
        rst = 1'b0;
        r = cyc;
        access("rd_cmp1_hi_after_rst", 32'h0200_400C, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b1, -1);
        access("rd_cmp0_lo_after_rst", 32'h0200_4000, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b1, -1);
        access("rd_msip1_after_rst", 32'h0200_0004, 1'b0, 32'h0, 32'h0, 1'b1, -1);
        access("rd_mtime_after_rst", 32'h0200_BFF8, 1'b0, 32'h0, 32'h0, 1'b1, r);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
